// File: rtl/code_entry_checker_if.sv
// Keypad-side inputs and lock-control-side outputs of the code entry checker.
// The keypad/lock side drives through master; the checker connects as slave.
interface code_entry_checker_if #(
    parameter int DIGITS  = 6,
    parameter int DIGIT_W = 4
);
    localparam int CODE_W = DIGITS * DIGIT_W;
    localparam int CNT_W  = $clog2(DIGITS + 1);

    logic              key_valid;
    logic [3:0]        key_code;
    logic [1:0]        mode;
    logic [CODE_W-1:0] ref_pc;
    logic [CODE_W-1:0] ref_uc;
    logic              correct;
    logic              wrong;
    logic [CODE_W-1:0] new_uc;
    logic              new_uc_valid;
    logic [CNT_W-1:0]  digit_count;
    logic              enroll_pending;
    logic              locked_out;

    modport master (
        output key_valid, key_code, mode, ref_pc, ref_uc,
        input  correct, wrong, new_uc, new_uc_valid, digit_count, enroll_pending, locked_out
    );

    modport slave (
        input  key_valid, key_code, mode, ref_pc, ref_uc,
        output correct, wrong, new_uc, new_uc_valid, digit_count, enroll_pending, locked_out
    );
endinterface

// File: rtl/code_entry_checker.sv
// Keypad code accumulator: compares entries against the programmed or user code,
// runs two-pass user-code enrolment and enforces a timed lockout after repeated failures.
module code_entry_checker #(
    parameter int DIGITS         = 6,
    parameter int DIGIT_W        = 4,
    parameter int MIN_DIGITS     = 4,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 12000000
) (
    input  logic                hwclk,
    input  logic                reset,
    code_entry_checker_if.slave bus
);
    localparam int CODE_W = DIGITS * DIGIT_W;
    localparam int CNT_W  = $clog2(DIGITS + 1);
    localparam int TMR_W  = $clog2(LOCKOUT_CYCLES + 1);
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DIGITS);
    localparam logic [CNT_W-1:0]  CNT_MIN   = CNT_W'(MIN_DIGITS);
    localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAILS - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(LOCKOUT_CYCLES - 1);

    localparam logic [1:0] MODE_PC     = 2'b00;
    localparam logic [1:0] MODE_UC     = 2'b01;
    localparam logic [1:0] MODE_ENROLL = 2'b10;
    localparam logic [3:0] KEY_ENTER   = 4'hA;
    localparam logic [3:0] KEY_CLEAR   = 4'hB;

    typedef enum logic [1:0] {ST_ENTRY, ST_EVAL, ST_DECIDE, ST_LOCKOUT} state_t;

    // Significant length of a user code: digits from the first non-zero one down to the LS digit.
    function automatic logic [CNT_W-1:0] uc_sig_len(input logic [CODE_W-1:0] r);
        logic             lead;
        logic [CNT_W-1:0] len;
        lead = 1'b1;
        len  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            lead = lead & (r[(DIGITS-1-i)*DIGIT_W +: DIGIT_W] == '0);
            if (!lead) len = len + 1'b1;
        end
        return len;
    endfunction

    function automatic logic uc_digits_match(input logic [CODE_W-1:0] b,
                                             input logic [CODE_W-1:0] r);
        logic lead;
        logic ok;
        lead = 1'b1;
        ok   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            lead = lead & (r[(DIGITS-1-i)*DIGIT_W +: DIGIT_W] == '0);
            if (!lead && (b[(DIGITS-1-i)*DIGIT_W +: DIGIT_W] != r[(DIGITS-1-i)*DIGIT_W +: DIGIT_W]))
                ok = 1'b0;
        end
        return ok;
    endfunction

    state_t            state;
    logic [1:0]        mode_r;
    logic [CODE_W-1:0] code_buf;
    logic [CNT_W-1:0]  count;
    logic [FAIL_W-1:0] fails;
    logic [TMR_W-1:0]  timer;
    logic [CODE_W-1:0] pend_code;
    logic              pending;

    logic [1:0]        mode_p1;
    logic              short_p1;
    logic              pc_ok_p1;
    logic              uc_ok_p1;
    logic              pend_ok_p1;
    logic [CODE_W-1:0] code_p1;

    logic              correct_r;
    logic              wrong_r;
    logic              new_uc_valid_r;
    logic [CODE_W-1:0] new_uc_r;
    logic              locked_r;

    logic              mode_chg;

    assign mode_chg = (bus.mode != mode_r);

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            state          <= ST_ENTRY;
            mode_r         <= '0;
            code_buf       <= '0;
            count          <= '0;
            fails          <= '0;
            timer          <= '0;
            pend_code      <= '0;
            pending        <= 1'b0;
            mode_p1        <= '0;
            short_p1       <= 1'b0;
            pc_ok_p1       <= 1'b0;
            uc_ok_p1       <= 1'b0;
            pend_ok_p1     <= 1'b0;
            code_p1        <= '0;
            correct_r      <= 1'b0;
            wrong_r        <= 1'b0;
            new_uc_valid_r <= 1'b0;
            new_uc_r       <= '0;
            locked_r       <= 1'b0;
        end else begin
            correct_r      <= 1'b0;
            wrong_r        <= 1'b0;
            new_uc_valid_r <= 1'b0;
            mode_r         <= bus.mode;

            case (state)
                ST_ENTRY: begin
                    if (bus.key_valid && !mode_chg) begin
                        if (bus.key_code <= 4'd9) begin
                            code_buf <= {code_buf[CODE_W-DIGIT_W-1:0], DIGIT_W'(bus.key_code)};
                            if (count != CNT_FULL) count <= count + 1'b1;
                        end else if (bus.key_code == KEY_ENTER) begin
                            state <= ST_EVAL;
                        end else if (bus.key_code == KEY_CLEAR) begin
                            code_buf <= '0;
                            count    <= '0;
                        end
                    end
                end

                // Stage 1: register every comparison outcome for the decision edge
                ST_EVAL: begin
                    mode_p1    <= mode_r;
                    short_p1   <= (count < CNT_MIN);
                    pc_ok_p1   <= (code_buf == bus.ref_pc);
                    uc_ok_p1   <= uc_digits_match(code_buf, bus.ref_uc) &&
                                  (count >= uc_sig_len(bus.ref_uc));
                    pend_ok_p1 <= (code_buf == pend_code);
                    code_p1    <= code_buf;
                    state      <= ST_DECIDE;
                end

                // Stage 2: emit the verdict, update counters, clear the entry
                ST_DECIDE: begin
                    code_buf <= '0;
                    count    <= '0;
                    state    <= ST_ENTRY;
                    case (mode_p1)
                        MODE_PC, MODE_UC: begin
                            if (!short_p1 && ((mode_p1 == MODE_PC) ? pc_ok_p1 : uc_ok_p1)) begin
                                correct_r <= 1'b1;
                                fails     <= '0;
                            end else begin
                                wrong_r <= 1'b1;
                                fails   <= fails + 1'b1;
                                if (fails == FAIL_LAST) begin
                                    state    <= ST_LOCKOUT;
                                    locked_r <= 1'b1;
                                    timer    <= '0;
                                end
                            end
                        end
                        MODE_ENROLL: begin
                            if (!pending) begin
                                if (short_p1) begin
                                    wrong_r <= 1'b1;
                                end else begin
                                    pend_code <= code_p1;
                                    pending   <= 1'b1;
                                end
                            end else begin
                                if (!short_p1 && pend_ok_p1) begin
                                    new_uc_r       <= pend_code;
                                    new_uc_valid_r <= 1'b1;
                                    correct_r      <= 1'b1;
                                end else begin
                                    wrong_r <= 1'b1;
                                end
                                pending <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end

                ST_LOCKOUT: begin
                    if (timer == TMR_LAST) begin
                        state    <= ST_ENTRY;
                        locked_r <= 1'b0;
                        fails    <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                default: state <= ST_ENTRY;
            endcase

            // A mode switch discards any partial entry and enrolment, overriding the FSM updates above.
            if (mode_chg) begin
                code_buf <= '0;
                count    <= '0;
                pending  <= 1'b0;
            end
        end
    end

    assign bus.correct        = correct_r;
    assign bus.wrong          = wrong_r;
    assign bus.new_uc         = new_uc_r;
    assign bus.new_uc_valid   = new_uc_valid_r;
    assign bus.digit_count    = count;
    assign bus.enroll_pending = pending;
    assign bus.locked_out     = locked_r;
endmodule

// File: tb/tb_code_entry_checker.sv
// Scoreboard bench for code_entry_checker: a digit-queue model predicts each verdict
// when ENTER is driven, and a negedge monitor pops and compares on the predicted cycle.
module tb_code_entry_checker;
    logic hwclk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   errs = 0;
    int   checks = 0;
    int   last_t = 0;
    int   lock_start = 0;
    int   guard = 0;

    always #5 hwclk = ~hwclk;
    always @(posedge hwclk) cyc <= cyc + 1;

    code_entry_checker_if #(.DIGITS(6), .DIGIT_W(4)) bus ();

    code_entry_checker #(
        .DIGITS(6), .DIGIT_W(4), .MIN_DIGITS(4), .MAX_FAILS(3), .LOCKOUT_CYCLES(16)
    ) dut (
        .hwclk(hwclk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int          due;
        logic        correct;
        logic        wrong;
        logic        nuv;
        logic        pend;
        logic        locked;
        logic [23:0] new_uc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          mbuf[$];
    int          mfails = 0;
    bit          mpend = 0;
    logic [23:0] mpend_code = '0;
    logic [23:0] mnew_uc = '0;
    int          mlock_end = -1;
    logic [1:0]  mmode = 2'b00;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [23:0] pack_buf();
        logic [23:0] v;
        v = '0;
        foreach (mbuf[i]) v = {v[19:0], 4'(mbuf[i])};
        return v;
    endfunction

    // Leading zeros of the user code are wildcards: only its significant tail must match.
    function automatic bit uc_ok();
        int len;
        int n;
        len = 0;
        n   = mbuf.size();
        for (int i = 0; i < 6; i++)
            if (len > 0 || bus.ref_uc[(5-i)*4 +: 4] != 4'd0) len++;
        if (n < len) return 1'b0;
        for (int j = 0; j < len; j++)
            if (mbuf[n-1-j] != int'(bus.ref_uc[j*4 +: 4])) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge hwclk);
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge hwclk);
        bus.key_valid = 1'b1;
        bus.key_code  = k;
        @(negedge hwclk);
        bus.key_valid = 1'b0;
        if (cyc > mlock_end) begin
            if (k <= 4'd9) begin
                mbuf.push_back(int'(k));
                if (mbuf.size() > 6) void'(mbuf.pop_front());
            end else if (k == 4'hB) begin
                mbuf.delete();
            end
        end
        check_val("digit_count", 64'(bus.digit_count), 64'(mbuf.size()));
    endtask

    task automatic press_seq(input logic [23:0] digits, input int n);
        logic [23:0] d;
        d = digits;
        for (int i = n - 1; i >= 0; i--) press(d[i*4 +: 4]);
    endtask

    task automatic enter();
        exp_t e;
        bit   ok;
        bit   shortx;
        int   t;
        @(negedge hwclk);
        bus.key_valid = 1'b1;
        bus.key_code  = 4'hA;
        @(negedge hwclk);
        bus.key_valid = 1'b0;
        t = cyc;
        if (t <= mlock_end) begin
            check_val("enter_ignored_count", 64'(bus.digit_count), 64'(mbuf.size()));
            return;
        end
        e.due = t + 2; e.correct = 0; e.wrong = 0; e.nuv = 0; e.locked = 0;
        shortx = (mbuf.size() < 4);
        case (mmode)
            2'b00, 2'b01: begin
                ok = !shortx && ((mmode == 2'b00) ? (pack_buf() == bus.ref_pc) : uc_ok());
                if (ok) begin
                    e.correct = 1; mfails = 0;
                end else begin
                    e.wrong = 1; mfails++;
                    if (mfails == 3) begin
                        e.locked  = 1;
                        mlock_end = t + 2 + 16;
                        mfails    = 0;
                    end
                end
            end
            2'b10: begin
                if (!mpend) begin
                    if (shortx) e.wrong = 1;
                    else begin mpend = 1; mpend_code = pack_buf(); end
                end else begin
                    if (!shortx && pack_buf() == mpend_code) begin
                        mnew_uc = mpend_code; e.nuv = 1; e.correct = 1;
                    end else begin
                        e.wrong = 1;
                    end
                    mpend = 0;
                end
            end
            default: ;
        endcase
        e.pend   = mpend;
        e.new_uc = mnew_uc;
        mbuf.delete();
        sb.push_back(e);
        last_t = t;
        wait_cyc(t + 2);
        check_val("count_after_enter", 64'(bus.digit_count), 64'd0);
    endtask

    task automatic set_mode(input logic [1:0] m);
        @(negedge hwclk);
        bus.mode = m;
        if (m != mmode) begin mbuf.delete(); mpend = 0; end
        mmode = m;
        @(negedge hwclk);
        check_val("mode_count", 64'(bus.digit_count), 64'(mbuf.size()));
    endtask

    task automatic do_reset(input string tag);
        @(negedge hwclk);
        #2;
        reset = 1'b1;
        #1;
        check_val(tag, {bus.correct, bus.wrong, bus.new_uc_valid, bus.locked_out,
                        bus.enroll_pending, bus.digit_count, bus.new_uc}, 64'd0);
        sb.delete(); mbuf.delete();
        mfails = 0; mpend = 0; mpend_code = '0; mnew_uc = '0; mlock_end = -1;
        @(negedge hwclk);
        @(negedge hwclk);
        reset = 1'b0;
    endtask

    always @(negedge hwclk) begin
        if (!reset) begin
            if (sb.size() != 0 && sb[0].due < cyc) begin
                check_val("late_result", 64'(cyc), 64'(sb[0].due));
                void'(sb.pop_front());
            end else if (sb.size() != 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                check_val("correct", 64'(bus.correct), 64'(mon_e.correct));
                check_val("wrong", 64'(bus.wrong), 64'(mon_e.wrong));
                check_val("new_uc_valid", 64'(bus.new_uc_valid), 64'(mon_e.nuv));
                check_val("new_uc", 64'(bus.new_uc), 64'(mon_e.new_uc));
                check_val("enroll_pending", 64'(bus.enroll_pending), 64'(mon_e.pend));
                check_val("locked_out", 64'(bus.locked_out), 64'(mon_e.locked));
            end else begin
                check_val("idle_pulses", 64'({bus.correct, bus.wrong, bus.new_uc_valid}), 64'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        bus.mode      = 2'b00;
        bus.ref_pc    = 24'h123456;
        bus.ref_uc    = 24'h004321;
        repeat (3) @(negedge hwclk);
        check_val("reset_state", {bus.correct, bus.wrong, bus.new_uc_valid, bus.locked_out,
                                  bus.enroll_pending, bus.digit_count, bus.new_uc}, 64'd0);
        reset = 1'b0;
        @(negedge hwclk);

        // Programmed code match
        press_seq(24'h123456, 6);
        enter();

        // User code with leading-zero wildcards, then a short entry
        set_mode(2'b01);
        press_seq(24'h094321, 5);
        enter();
        press_seq(24'h000432, 3);
        enter();

        // Clear the fail count, then three failures into lockout
        set_mode(2'b00);
        press_seq(24'h123456, 6);
        enter();
        repeat (3) begin
            press_seq(24'h001111, 4);
            enter();
        end
        lock_start = last_t + 2;
        check_val("lock_rise", 64'(bus.locked_out), 64'd1);
        press(4'd5);
        press(4'd5);
        enter();
        check_val("lock_hold", 64'(bus.locked_out), 64'd1);
        guard = 0;
        while (bus.locked_out && guard < 100) begin
            @(negedge hwclk);
            guard++;
        end
        check_val("lock_len", 64'(cyc - lock_start), 64'd16);
        press_seq(24'h123456, 6);
        enter();

        // Enrolment: matching pair, then a mismatched pair
        set_mode(2'b10);
        press_seq(24'h005566, 4);
        enter();
        press_seq(24'h005566, 4);
        enter();
        press_seq(24'h005566, 4);
        enter();
        press_seq(24'h005567, 4);
        enter();

        // Saturating buffer and CLEAR
        set_mode(2'b00);
        bus.ref_pc = 24'h777777;
        repeat (8) press(4'd7);
        enter();
        press(4'd7);
        press(4'd7);
        press(4'hB);

        // Reserved mode: ENTER only clears
        set_mode(2'b11);
        press_seq(24'h001234, 4);
        enter();

        // Mode change mid-entry
        set_mode(2'b00);
        press(4'd1);
        press(4'd2);
        set_mode(2'b01);

        // Reset with an enrolment pending
        set_mode(2'b10);
        press_seq(24'h001234, 4);
        enter();
        check_val("pend_before_reset", 64'(bus.enroll_pending), 64'd1);
        do_reset("rst_pending");

        // Reset in the middle of a lockout
        bus.ref_pc = 24'h123456;
        set_mode(2'b00);
        repeat (3) begin
            press_seq(24'h001111, 4);
            enter();
        end
        repeat (4) @(negedge hwclk);
        do_reset("rst_lockout");
        @(negedge hwclk);
        check_val("no_lock_after_reset", 64'(bus.locked_out), 64'd0);
        press_seq(24'h123456, 6);
        enter();

        repeat (4) @(negedge hwclk);
        check_val("sb_drain", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/code_entry_checker.md
Name: code_entry_checker

Overview:
- Parametrised successor to the lock's six-digit validity checker.
- Runs on hwclk with a synchronous key strobe, not a button-edge clock.
- Accumulates keypad digits and evaluates them on ENTER against the programmed code (PC) or user code (UC).
- Runs a two-pass UC enrolment, counts failed attempts and enforces a timed lockout.
- Sits between the keypad debouncer/decoder and the lock-control FSM.

Parameters:
- DIGITS, 6: maximum code length in digits.
- DIGIT_W, 4: bits per digit.
- MIN_DIGITS, 4: minimum entered digits for an evaluation to be considered.
- MAX_FAILS, 3: consecutive compare failures that trigger lockout.
- LOCKOUT_CYCLES, 12000000: lockout duration in hwclk cycles (1 s at 12 MHz). Counter width is clog2(LOCKOUT_CYCLES+1).

Ports:
- hwclk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- key_valid  in  1  one-cycle strobe; key_code is valid this cycle.
- key_code  in  4  0-9 digit, 4'hA ENTER, 4'hB CLEAR; 4'hC-4'hF ignored.
- mode  in  2  00 CMP_PC, 01 CMP_UC, 10 ENROLL, 11 reserved.
- ref_pc  in  DIGITS*DIGIT_W  programmed code; digit 0 in the MS nibble.
- ref_uc  in  DIGITS*DIGIT_W  current user code, same packing.
- correct  out  1  one-cycle pulse: evaluation passed.
- wrong  out  1  one-cycle pulse: evaluation failed.
- new_uc  out  DIGITS*DIGIT_W  last enrolled UC, registered.
- new_uc_valid  out  1  one-cycle pulse when new_uc is updated.
- digit_count  out  clog2(DIGITS+1)  digits currently buffered.
- enroll_pending  out  1  first enrolment pass has been captured.
- locked_out  out  1  high for the whole lockout period.

Behaviour:
- Reset: every output 0, buffer/count/fail counter/pending/lockout timer 0, state ENTRY, mode register 0. Reset mid-evaluation or mid-lockout aborts immediately. No pulse is emitted on release.
- Buffer: DIGITS x DIGIT_W shift register, right-aligned. A digit shifts in at the LS nibble and the rest shift toward the MS nibble. digit_count increments and saturates at DIGITS. Once full, the oldest digit is dropped.
- CLEAR in ENTRY: buffer and count go to 0. Fail counter and enroll_pending are unchanged.
- Mode register: sampled every cycle. If mode differs from the registered value, buffer, count and enroll_pending clear on that edge. Any key in the same cycle is discarded.
- ENTER in ENTRY moves the FSM to EVAL. key_valid is ignored in EVAL and LOCKOUT.
- Latency: ENTER sampled at edge t, EVAL during cycle t+1, correct/wrong/new_uc_valid high for exactly the cycle after edge t+2. Buffer and count clear at edge t+2.
- Short entry (digit_count < MIN_DIGITS): evaluates as wrong in every mode.
- CMP_PC: all DIGITS buffer digits equal ref_pc digits.
- CMP_UC: per digit, match if equal OR that ref_uc digit and all more-significant ref_uc digits are 0 (leading zeros are wildcards). digit_count must be at least the UC's significant length.
- Fail counter (CMP_PC/CMP_UC only): correct clears it; wrong increments it.
- On reaching MAX_FAILS the FSM enters LOCKOUT at the same edge as the wrong pulse. locked_out rises with wrong.
- LOCKOUT: lasts LOCKOUT_CYCLES cycles. On exit, locked_out falls, the fail counter clears, and the FSM returns to ENTRY.
- ENROLL, enroll_pending=0: an accepted entry is captured to a pending register and enroll_pending goes to 1. No correct/wrong pulse.
- ENROLL, enroll_pending=1: buffer equal to pending gives new_uc <= pending, new_uc_valid and correct pulses, pending cleared. Mismatch gives a wrong pulse and pending cleared. Enrol failures never touch the fail counter.
- mode 11: ENTER returns to ENTRY with no pulse; buffer cleared.
- correct and wrong are never high together.

Test Plan:
Parameters for all scenarios: DIGITS=6, MIN_DIGITS=4, MAX_FAILS=3, LOCKOUT_CYCLES=16.
- CMP_PC, ref_pc=24'h123456, keys 1,2,3,4,5,6,ENTER -> correct pulse exactly 2 cycles after the ENTER strobe; digit_count 6 then 0; wrong stays 0.
- CMP_UC, ref_uc=24'h004321, keys 9,4,3,2,1,ENTER -> correct (leading-zero wildcards). Keys 4,3,2,ENTER -> wrong (short entry).
- CMP_PC, three wrong entries of 1,1,1,1,ENTER -> wrong x3. locked_out rises with the third wrong and holds 16 cycles. Keys during lockout leave digit_count at 0. Afterwards 123456,ENTER -> correct.
- ENROLL, 5,5,6,6,ENTER then 5,5,6,6,ENTER -> enroll_pending 1 then 0; new_uc=24'h005566 with new_uc_valid and correct pulses. Repeat with a mismatched second pass -> wrong, new_uc unchanged.
- Keys 7 x8 then ENTER in CMP_PC with ref_pc=24'h777777 -> digit_count saturates at 6, correct. CLEAR mid-entry resets count to 0.
- Assert reset during LOCKOUT and during a pending enrolment -> all outputs 0 asynchronously. A mode change mid-entry clears the buffer.
